// File: rtl/arb_req_collector.sv
// Request collector in front of a combinational fixed-priority arbiter.
// Pulses become sticky pending bits, and each validated grant is held for HOLD cycles.

module arb_req_collector_lane (
  input  logic clk,
  input  logic resetn,
  input  logic req,
  input  logic clr,
  output logic pend,
  output logic merge
);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend  <= 1'b0;
      merge <= 1'b0;
    end else begin
      // A new pulse wins over a retire in the same cycle
      pend <= (pend & ~clr) | req;
      if (req & pend & ~clr) merge <= 1'b1;
    end
  end
endmodule

module arb_req_collector #(
  parameter int PORTS = 4,
  parameter int HOLD  = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [PORTS-1:0] req_pulse,
  output logic [PORTS-1:0] pend_req,
  input  logic [PORTS-1:0] arb_gnt,
  output logic [PORTS-1:0] gnt_out,
  output logic             gnt_valid,
  output logic             done,
  output logic [PORTS-1:0] merge_flag,
  output logic             gnt_err
);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t           state, state_nxt;
  logic [7:0]       cnt;
  logic [PORTS-1:0] clr;
  logic             gnt_ok;

  assign clr    = (state == RELEASE) ? gnt_out : '0;
  // Legal grant: exactly one bit, and only for a port that is pending
  assign gnt_ok = (arb_gnt != '0) && ((arb_gnt & (arb_gnt - 1'b1)) == '0) &&
                  ((arb_gnt & ~pend_req) == '0);

  for (genvar i = 0; i < PORTS; i++) begin : g_lane
    arb_req_collector_lane u_lane (
      .clk    (clk),
      .resetn (resetn),
      .req    (req_pulse[i]),
      .clr    (clr[i]),
      .pend   (pend_req[i]),
      .merge  (merge_flag[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend_req != '0 && gnt_ok) state_nxt = GRANT;
      GRANT:   if (cnt == 8'd0) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_valid = (state == GRANT);
    done      = (state == RELEASE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      gnt_out <= '0;
      cnt     <= 8'd0;
      gnt_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pend_req != '0) begin
          if (gnt_ok) begin
            gnt_out <= arb_gnt;
            cnt     <= 8'(HOLD - 1);
          end else begin
            gnt_err <= 1'b1;
          end
        end
        GRANT:   if (cnt != 8'd0) cnt <= cnt - 8'd1;
        RELEASE: gnt_out <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_arb_req_collector.sv
// Directed bench for arb_req_collector with a bit0-highest fixed-priority arbiter model.
module tb_arb_req_collector;
  localparam int PORTS = 4;
  localparam int HOLD  = 3;

  logic             clk = 1'b0;
  logic             resetn;
  logic [PORTS-1:0] req_pulse, pend_req, arb_gnt, gnt_out, merge_flag;
  logic             gnt_valid, done, gnt_err;
  logic             frc_en;
  logic [PORTS-1:0] frc_val;
  int               n_run = 0, n_fail = 0;

  always #5 clk = ~clk;

  // Arbiter model: lowest set bit wins, unless overridden to inject a bad grant
  assign arb_gnt = frc_en ? frc_val : (pend_req & (~pend_req + 1'b1));

  arb_req_collector #(.PORTS(PORTS), .HOLD(HOLD)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_pulse  (req_pulse),
    .pend_req   (pend_req),
    .arb_gnt    (arb_gnt),
    .gnt_out    (gnt_out),
    .gnt_valid  (gnt_valid),
    .done       (done),
    .merge_flag (merge_flag),
    .gnt_err    (gnt_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starting from IDLE with the winning port pending: HOLD valid cycles then done
  task automatic tenure(input string tag, input logic [PORTS-1:0] m);
    for (int i = 0; i < HOLD; i++) begin
      tick();
      chk({tag, "_gv"}, gnt_valid, 1);
      chk({tag, "_gnt"}, gnt_out, m);
      chk({tag, "_done0"}, done, 0);
    end
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_gv_rel"}, gnt_valid, 0);
    chk({tag, "_gnt_rel"}, gnt_out, m);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; req_pulse = '0; frc_en = 1'b0; frc_val = '0;
    tick(); tick();
    chk("rst_pend", pend_req, 0);
    chk("rst_gnt", gnt_out, 0);
    chk("rst_gv", gnt_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_merge", merge_flag, 0);
    chk("rst_err", gnt_err, 0);
    resetn = 1'b1;

    // Reset mid-tenure
    req_pulse = 4'b0100; tick(); req_pulse = '0;
    tick(); chk("mid_gv", gnt_valid, 1);
    tick();
    resetn = 1'b0; tick();
    chk("mid_gv0", gnt_valid, 0);
    chk("mid_done0", done, 0);
    chk("mid_pend0", pend_req, 0);
    chk("mid_gnt0", gnt_out, 0);
    resetn = 1'b1;
    for (int i = 0; i < HOLD + 2; i++) begin
      tick();
      chk("mid_nodone", done, 0);
      chk("mid_idle_gv", gnt_valid, 0);
    end

    // Single request
    req_pulse = 4'b0100; tick(); req_pulse = '0;
    chk("one_pend", pend_req, 4'b0100);
    chk("one_gv0", gnt_valid, 0);
    tenure("one", 4'b0100);
    tick();
    chk("one_pend_end", pend_req, 0);
    chk("one_gnt_end", gnt_out, 0);
    chk("one_done_end", done, 0);

    // Simultaneous requests: port1 then port3 with one IDLE cycle between
    req_pulse = 4'b1010; tick(); req_pulse = '0;
    chk("sim_pend", pend_req, 4'b1010);
    tenure("sim_p1", 4'b0010);
    tick();
    chk("sim_gap_gv", gnt_valid, 0);
    chk("sim_gap_pend", pend_req, 4'b1000);
    tenure("sim_p3", 4'b1000);
    tick();
    chk("sim_pend_end", pend_req, 0);

    // Late higher-priority request does not preempt
    req_pulse = 4'b0100; tick(); req_pulse = '0;
    tick(); chk("late_gnt1", gnt_out, 4'b0100);
    req_pulse = 4'b0001; tick(); req_pulse = '0;
    chk("late_pend", pend_req, 4'b0101);
    chk("late_gnt2", gnt_out, 4'b0100);
    chk("late_gv2", gnt_valid, 1);
    tick(); chk("late_gnt3", gnt_out, 4'b0100);
    tick(); chk("late_done", done, 1);
    chk("late_gnt_rel", gnt_out, 4'b0100);
    tick(); chk("late_pend_mid", pend_req, 4'b0001);
    tenure("late_p0", 4'b0001);
    tick(); chk("late_pend_end", pend_req, 0);
    chk("merge_none", merge_flag, 0);

    // Merge: two pulses on port3 before grant give one tenure
    req_pulse = 4'b1000; tick();
    tick(); req_pulse = '0;
    chk("mrg_flag", merge_flag, 4'b1000);
    chk("mrg_gv", gnt_valid, 1);
    chk("mrg_gnt", gnt_out, 4'b1000);
    tick(); tick();
    tick(); chk("mrg_done", done, 1);
    tick(); chk("mrg_pend_end", pend_req, 0);
    tick(); chk("mrg_no_second", gnt_valid, 0);

    // Set wins: pulse on port3 in its RELEASE cycle keeps the bit
    req_pulse = 4'b1000; tick(); req_pulse = '0;
    tick(); tick(); tick();
    tick(); chk("sw_done", done, 1);
    req_pulse = 4'b1000; tick(); req_pulse = '0;
    chk("sw_pend", pend_req, 4'b1000);
    chk("sw_gnt0", gnt_out, 0);
    tenure("sw_p3", 4'b1000);
    tick(); chk("sw_pend_end", pend_req, 0);
    chk("sw_merge_sticky", merge_flag, 4'b1000);
    chk("err_none", gnt_err, 0);

    // Illegal grant then recovery
    frc_en = 1'b1; frc_val = 4'b0011;
    req_pulse = 4'b0011; tick(); req_pulse = '0;
    chk("ill_pend", pend_req, 4'b0011);
    tick();
    chk("ill_err", gnt_err, 1);
    chk("ill_gv", gnt_valid, 0);
    tick();
    chk("ill_gv2", gnt_valid, 0);
    chk("ill_gnt", gnt_out, 0);
    frc_en = 1'b0;
    tenure("ill_p0", 4'b0001);
    tick(); chk("ill_pend_mid", pend_req, 4'b0010);
    tenure("ill_p1", 4'b0010);
    tick(); chk("ill_pend_end", pend_req, 0);
    chk("ill_err_sticky", gnt_err, 1);

    // Sticky flags clear only on reset
    resetn = 1'b0; tick();
    chk("fin_merge", merge_flag, 0);
    chk("fin_err", gnt_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
